// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
//   Reset sequencer on the 50 MHz reference clock. It pulses the PLL reset and
//   waits for the PLL's asynchronous lock indication. Lock must then hold for
//   a stability window before the active-low system reset for the audio-clock
//   domains is released. Lock timeouts cause a retry. After MAX_RETRY
//   timeouts the sequencer parks in FAIL. Loss of lock in RUN, or a soft
//   request, starts the sequence again.
//
// Ports
//   refclk     in   reference clock, sole clock of this block
//   rst_n      in   asynchronous active-low reset
//   locked     in   PLL lock, asynchronous to refclk (synchronized internally)
//   soft_rst   in   synchronous level request; high holds the sequence at start
//   pll_rst    out  active-high PLL reset (registered)
//   sys_rst_n  out  active-low downstream system reset (registered)
//   ready      out  high only in RUN (registered)
//   fail       out  high only in FAIL (registered)
//   retry_cnt  out  lock timeouts taken in the current sequence
// -----------------------------------------------------------------------------
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_RST_END  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TO_END   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STB_END  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam logic [3:0]       C_RETRY_LAST = 4'(MAX_RETRY - 1);

  logic             r_lk_s1;
  logic             r_lk_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic             r_fail;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       w_retry_nxt;
  logic             w_pll_rst_nxt;
  logic             w_sys_rst_n_nxt;
  logic             w_ready_nxt;
  logic             w_fail_nxt;

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lk_s1 <= 1'b0;
      r_lk_s  <= 1'b0;
    end else begin
      r_lk_s1 <= locked;
      r_lk_s  <= r_lk_s1;
    end
  end

  // State register, shared cycle counter and retry count
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_PLL_RST;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  // Saturating increment: the counter never wraps back into a match window
  assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // Next-state logic; soft_rst overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_retry_nxt = r_retry;
    if (soft_rst) begin
      w_state_nxt = S_PLL_RST;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        S_PLL_RST: begin
          if (r_cnt == C_RST_END) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lk_s) begin
            w_state_nxt = S_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_TO_END) begin
            w_cnt_nxt = '0;
            if (r_retry == C_RETRY_LAST) begin
              w_state_nxt = S_FAIL;
            end else begin
              w_state_nxt = S_PLL_RST;
              w_retry_nxt = r_retry + 4'd1;
            end
          end
        end
        S_STABLE: begin
          // A lock drop restarts the timeout window without charging a retry
          if (!r_lk_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_STB_END) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end
        end
        S_RUN: begin
          w_cnt_nxt = '0;
          if (!r_lk_s) begin
            w_state_nxt = S_PLL_RST;
            w_retry_nxt = '0;
          end
        end
        S_FAIL: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so the registered copies change on
  // the same edge as the state itself
  always_comb begin
    w_pll_rst_nxt   = (w_state_nxt == S_PLL_RST);
    w_sys_rst_n_nxt = (w_state_nxt == S_RUN);
    w_ready_nxt     = (w_state_nxt == S_RUN);
    w_fail_nxt      = (w_state_nxt == S_FAIL);
  end

  // Output registers; sys_rst_n can only rise on the edge that enters RUN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_pll_rst   <= w_pll_rst_nxt;
      r_sys_rst_n <= w_sys_rst_n_nxt;
      r_ready     <= w_ready_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_seq
//   Directed bench for pll_rst_seq with shortened timing parameters. Each
//   stimulus step queues the output changes it should cause, as
//   (edge number, {pll_rst, sys_rst_n, ready, fail, retry_cnt}). A monitor
//   pops and compares one entry whenever the output vector changes.
// -----------------------------------------------------------------------------
module tb_pll_rst_seq;

  localparam int PRC = 16;
  localparam int TO  = 300;
  localparam int LS  = 64;
  localparam int MR  = 3;
  localparam int CW  = 12;

  logic       refclk   = 1'b0;
  logic       rst_n    = 1'b1;
  logic       locked   = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;

  pll_rst_seq #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (TO),
    .LOCK_STABLE   (LS),
    .MAX_RETRY     (MR),
    .CNT_W         (CW)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .locked   (locked),
    .soft_rst (soft_rst),
    .pll_rst  (pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready    (ready),
    .fail     (fail),
    .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;

  // Number of rising edges seen so far
  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] ov;
  } ev_t;

  ev_t        exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  bit         mon_en   = 1'b0;
  logic [7:0] prev;
  logic [7:0] cur;

  assign cur = {pll_rst, sys_rst_n, ready, fail, retry_cnt};

  function automatic logic [7:0] ov(input logic p, input logic s, input logic r,
                                    input logic f, input logic [3:0] rc);
    return {p, s, r, f, rc};
  endfunction

  task automatic expect_ev(input int c, input logic [7:0] v);
    ev_t e;
    e.cyc = c;
    e.ov  = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%b required=%b (p,s,r,f,retry)", nm, got, req);
    end
  endtask

  // Advance to 2 time units after rising edge number t
  task automatic goto_cyc(input int t);
    if (t <= cyc) begin
      checks++;
      failures++;
      $display("FAIL schedule now=%0d required_after=%0d", cyc, t);
    end else begin
      while (cyc < t) begin
        @(posedge refclk);
        #2;
      end
    end
  endtask

  // Monitor: any output change must match the next queued expectation
  always @(negedge refclk) begin : monitor
    ev_t e;
    if (mon_en && (cur !== prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, cur, prev);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != cyc) || (e.ov !== cur)) begin
          failures++;
          $display("FAIL event cyc=%0d got=%b required cyc=%0d outs=%b",
                   cyc, cur, e.cyc, e.ov);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #40000;
    $display("FAIL watchdog cyc=%0d required=finish_by_2800", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset: outputs take reset values with no clock edge
    #1 rst_n = 1'b0;
    #1 chk("reset_state", cur, ov(1, 0, 0, 0, 4'd0));
    prev   = cur;
    mon_en = 1'b1;

    // Nominal lock: pll_rst falls PRC edges after release, run LS+3 after lock
    goto_cyc(2);
    rst_n = 1'b1;
    expect_ev(2 + PRC, ov(0, 0, 0, 0, 4'd0));
    goto_cyc(218);
    locked = 1'b1;
    expect_ev(218 + 3 + LS, ov(0, 1, 1, 0, 4'd0));

    // Loss of lock in RUN: release drops 3 edges later, new pulse follows
    goto_cyc(300);
    locked = 1'b0;
    expect_ev(303, ov(1, 0, 0, 0, 4'd0));
    expect_ev(303 + PRC, ov(0, 0, 0, 0, 4'd0));
    goto_cyc(310);
    locked = 1'b1;
    expect_ev(320 + LS, ov(0, 1, 1, 0, 4'd0));

    // Lock chatter inside the stability window: no outputs move until the
    // window restarts and completes after the final rise
    goto_cyc(400);
    locked = 1'b0;
    expect_ev(403, ov(1, 0, 0, 0, 4'd0));
    expect_ev(419, ov(0, 0, 0, 0, 4'd0));
    goto_cyc(440);
    locked = 1'b1;
    goto_cyc(473);
    locked = 1'b0;
    goto_cyc(476);
    locked = 1'b1;
    expect_ev(479 + LS, ov(0, 1, 1, 0, 4'd0));

    // One timeout, then lock during the second attempt
    goto_cyc(600);
    locked = 1'b0;
    expect_ev(603, ov(1, 0, 0, 0, 4'd0));
    expect_ev(619, ov(0, 0, 0, 0, 4'd0));
    expect_ev(619 + TO, ov(1, 0, 0, 0, 4'd1));
    expect_ev(619 + TO + PRC, ov(0, 0, 0, 0, 4'd1));
    goto_cyc(950);
    locked = 1'b1;
    expect_ev(953 + LS, ov(0, 1, 1, 0, 4'd1));

    // Loss of lock clears retry_cnt; lock never returns so retries exhaust
    goto_cyc(1100);
    locked = 1'b0;
    expect_ev(1103, ov(1, 0, 0, 0, 4'd0));
    expect_ev(1119, ov(0, 0, 0, 0, 4'd0));
    expect_ev(1419, ov(1, 0, 0, 0, 4'd1));
    expect_ev(1435, ov(0, 0, 0, 0, 4'd1));
    expect_ev(1735, ov(1, 0, 0, 0, 4'd2));
    expect_ev(1751, ov(0, 0, 0, 0, 4'd2));
    expect_ev(2051, ov(0, 0, 0, 1, 4'd2));

    // FAIL holds with no output activity, then soft_rst restarts
    goto_cyc(2300);
    chk("fail_hold", cur, ov(0, 0, 0, 1, 4'd2));
    soft_rst = 1'b1;
    expect_ev(2301, ov(1, 0, 0, 0, 4'd0));
    expect_ev(2301 + PRC, ov(0, 0, 0, 0, 4'd0));
    goto_cyc(2301);
    soft_rst = 1'b0;
    goto_cyc(2330);
    locked = 1'b1;
    expect_ev(2333 + LS, ov(0, 1, 1, 0, 4'd0));

    // soft_rst held for 5 edges in RUN; counting resumes after release
    goto_cyc(2450);
    soft_rst = 1'b1;
    expect_ev(2451, ov(1, 0, 0, 0, 4'd0));
    expect_ev(2455 + PRC, ov(0, 0, 0, 0, 4'd0));
    expect_ev(2472 + LS, ov(0, 1, 1, 0, 4'd0));
    goto_cyc(2455);
    soft_rst = 1'b0;

    // Asynchronous reset in the middle of STABLE
    goto_cyc(2600);
    locked = 1'b0;
    expect_ev(2603, ov(1, 0, 0, 0, 4'd0));
    expect_ev(2619, ov(0, 0, 0, 0, 4'd0));
    goto_cyc(2620);
    locked = 1'b1;
    goto_cyc(2640);
    chk("mid_stable", cur, ov(0, 0, 0, 0, 4'd0));
    expect_ev(2640, ov(1, 0, 0, 0, 4'd0));
    rst_n = 1'b0;
    #1 chk("async_reset", cur, ov(1, 0, 0, 0, 4'd0));
    goto_cyc(2650);
    chk("reset_held", cur, ov(1, 0, 0, 0, 4'd0));
    rst_n = 1'b1;
    expect_ev(2650 + PRC, ov(0, 0, 0, 0, 4'd0));
    expect_ev(2667 + LS, ov(0, 1, 1, 0, 4'd0));

    goto_cyc(2800);
    chk("run_final", cur, ov(0, 1, 1, 0, 4'd0));
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d required=0 next_cyc=%0d",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
